conv_engine: RTL and testbench

Streaming 2-D convolution engine for the MobileNet pipeline. It accepts one unsigned pixel per handshake in raster order and keeps the last window_dim rows in an internal line buffer. For every fully populated window position allowed by the stride, it computes a signed multiply-accumulate of the window against a programmable kernel plus bias and presents one 32-bit result. It sits between the image/feature-map source and the downstream activation/writeback stage.

---
 rtl/conv_engine_if.sv | 27 ++
 rtl/conv_engine.sv | 163 ++++++++++++++++
 tb/tb_conv_engine.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_engine_if.sv
// Streaming handshake bundle between the pixel source, the convolution engine and the downstream
// activation/writeback stage.
//   newPixelData / new_data_valid : pixel stream into the engine (source -> engine)
//   idle_out                      : engine can take a pixel this cycle (engine -> source)
//   result / resultValid          : convolution result stream (engine -> sink)
//   out_accepting_values          : sink ready (sink -> engine)
// master: the pixel source plus result sink side. slave: the engine.
interface conv_engine_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] newPixelData;
  logic                  new_data_valid;
  logic                  idle_out;
  logic [31:0]           result;
  logic                  resultValid;
  logic                  out_accepting_values;

  modport master (
    output newPixelData, new_data_valid, out_accepting_values,
    input  idle_out, result, resultValid
  );

  modport slave (
    input  newPixelData, new_data_valid, out_accepting_values,
    output idle_out, result, resultValid
  );
endinterface

// File: rtl/conv_engine.sv
// Streaming 2-D convolution engine. Takes unsigned pixels in raster order, keeps the last
// (N-1)*input_dim+N pixels in a shift-register line buffer, and for every complete window allowed
// by the stride computes sum(weight*pixel + bias) over the N*N taps, MULT_PER_CYCLE taps per cycle.
// Ports:
//   clock, reset (async, active low)
//   weights, biases : nine signed taps each, packed [8:0]
//   stride          : 0 = every window, 1 = every second window in both directions
//   input_dim       : square image side (3..255)
//   window_dim      : kernel side N (0 treated as 1)
//   bus             : pixel in / result out handshake (slave side)
module conv_engine #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MULT_PER_CYCLE = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [8:0][DATA_WIDTH-1:0] weights,
  input  logic [8:0][DATA_WIDTH-1:0] biases,
  input  logic                       stride,
  input  logic [7:0]                 input_dim,
  input  logic [1:0]                 window_dim,
  conv_engine_if.slave               bus
);
  localparam int unsigned LbDepth = 513;
  localparam int unsigned ProdW   = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  state_e             state_q, state_d;
  logic [7:0]         row_q, row_d, col_q, col_d;
  logic [3:0]         cyc_q, cyc_d;
  logic signed [31:0] acc_q, acc_d, result_q, result_d;
  logic [DATA_WIDTH-1:0] lb_q [LbDepth];

  int unsigned        n, n_sq, n_cyc;
  logic               accept, win_ok, last_cyc;
  logic [31:0]        part_sum;

  // Per-tap temporaries for the multiply loop.
  int unsigned             t, r, c;
  logic                    tap_ok;
  logic [9:0]              off;
  logic [3:0]              widx;
  logic [DATA_WIDTH-1:0]   w, b, pix;
  logic signed [ProdW-1:0] w_ext, p_ext, prod;

  always_comb begin
    n        = (window_dim == 2'd0) ? 32'd1 : 32'(window_dim);
    n_sq     = n * n;
    n_cyc    = (n_sq + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
    last_cyc = (32'(cyc_q) + 1 >= n_cyc);
    accept   = bus.new_data_valid && (state_q == StIdle);
    // Window check uses the position of the pixel being accepted (counters before update).
    win_ok   = (32'(row_q) + 1 >= n) && (32'(col_q) + 1 >= n);
    if (stride) begin
      win_ok = win_ok && ((32'(row_q) + 1 - n) % 2 == 0) && ((32'(col_q) + 1 - n) % 2 == 0);
    end
  end

  // Taps are numbered t = r*N + c; lb_q[0] is the newest pixel (window bottom-right), so tap
  // (r,c) sits (N-1-r) rows and (N-1-c) pixels back in the buffer.
  always_comb begin
    part_sum = '0;
    t        = 0;
    r        = 0;
    c        = 0;
    tap_ok   = 1'b0;
    off      = '0;
    widx     = '0;
    w        = '0;
    b        = '0;
    pix      = '0;
    w_ext    = '0;
    p_ext    = '0;
    prod     = '0;
    for (int unsigned k = 0; k < MULT_PER_CYCLE; k++) begin
      t      = 32'(cyc_q) * MULT_PER_CYCLE + k;
      tap_ok = (t < n_sq);
      r      = tap_ok ? t / n : 0;
      c      = tap_ok ? t % n : 0;
      off    = 10'((n - 1 - r) * 32'(input_dim) + (n - 1 - c));
      widx   = tap_ok ? 4'(n_sq - 1 - t) : 4'd0;
      w      = weights[widx];
      b      = biases[widx];
      pix    = lb_q[off];
      w_ext  = {{(ProdW - DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
      p_ext  = {{(ProdW - DATA_WIDTH){1'b0}}, pix};
      prod   = w_ext * p_ext;
      if (tap_ok) begin
        part_sum = part_sum + {{(32 - ProdW){prod[ProdW-1]}}, prod}
                            + {{(32 - DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cyc_d    = cyc_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (col_q == input_dim - 8'd1) begin
            col_d = '0;
            row_d = (row_q == input_dim - 8'd1) ? 8'd0 : row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          if (win_ok) begin
            state_d = StCompute;
            cyc_d   = '0;
            acc_d   = '0;
          end
        end
      end
      StCompute: begin
        acc_d = acc_q + part_sum;
        cyc_d = cyc_q + 4'd1;
        if (last_cyc) begin
          result_d = acc_q + part_sum;
          state_d  = StOutput;
        end
      end
      StOutput: begin
        if (bus.out_accepting_values) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      cyc_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cyc_q    <= cyc_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Line buffer contents need no reset; stale pixels are never used before a full window forms.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb_q[0] <= bus.newPixelData;
      for (int i = 1; i < LbDepth; i++) lb_q[i] <= lb_q[i-1];
    end
  end

  assign bus.result      = result_q;
  assign bus.resultValid = (state_q == StOutput);
  assign bus.idle_out    = (state_q == StIdle);
endmodule

// File: tb/tb_conv_engine.sv
module tb_conv_engine;
  logic             clock = 1'b0;
  logic             reset;
  logic [8:0][7:0]  weights;
  logic [8:0][7:0]  biases;
  logic             stride;
  logic [7:0]       input_dim;
  logic [1:0]       window_dim;

  conv_engine_if #(.DATA_WIDTH(8)) bus ();

  conv_engine #(.DATA_WIDTH(8), .MULT_PER_CYCLE(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .weights    (weights),
    .biases     (biases),
    .stride     (stride),
    .input_dim  (input_dim),
    .window_dim (window_dim),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int         n_tests;
  int         n_fail;
  int         w_arr [9];
  int         b_arr [9];
  logic [7:0] img [16][16];
  int         got_val [$];
  int         got_pos [$];
  int         exp_val [$];
  int         exp_pos [$];

  task automatic set_taps(input int wv, input int bv);
    for (int i = 0; i < 9; i++) begin
      w_arr[i] = wv;
      b_arr[i] = bv;
    end
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 9; i++) begin
      w_arr[i] = int'($urandom_range(255)) - 128;
      b_arr[i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic rand_img(input int d);
    for (int r = 0; r < d; r++)
      for (int c = 0; c < d; c++) img[r][c] = 8'($urandom);
  endtask

  task automatic apply_cfg(input int d, input int wd, input bit st);
    input_dim  = 8'(d);
    window_dim = 2'(wd);
    stride     = st;
    for (int i = 0; i < 9; i++) begin
      weights[i] = 8'(w_arr[i]);
      biases[i]  = 8'(b_arr[i]);
    end
  endtask

  // Reference: walk every raster position and convolve the explicit 2-D image directly.
  function automatic void model_frame(input int d, input int wd, input bit st);
    int n;
    int sum;
    int tap;
    n = (wd == 0) ? 1 : wd;
    exp_val.delete();
    exp_pos.delete();
    for (int row = 0; row < d; row++) begin
      for (int col = 0; col < d; col++) begin
        if (row >= n - 1 && col >= n - 1 &&
            (!st || (((row - n + 1) % 2 == 0) && ((col - n + 1) % 2 == 0)))) begin
          sum = 0;
          for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
              tap = n * n - 1 - (r * n + c);
              sum += w_arr[tap] * int'(img[row - n + 1 + r][col - n + 1 + c]) + b_arr[tap];
            end
          end
          exp_val.push_back(sum);
          exp_pos.push_back(row * d + col);
        end
      end
    end
  endfunction

  // Streams one frame; records each accepted result and the index of the pixel that ended its window.
  task automatic run_frame(input int d, input int acc_pct, output bit timeout);
    int idx;
    int total;
    int budget;
    bit fin;
    idx = 0;
    total = d * d;
    budget = total * 10 + 100;
    fin = 1'b0;
    timeout = 1'b0;
    got_val.delete();
    got_pos.delete();
    while (!fin) begin
      @(negedge clock);
      bus.new_data_valid       = (idx < total);
      bus.newPixelData         = (idx < total) ? img[idx / d][idx % d] : 8'h00;
      bus.out_accepting_values = (int'($urandom_range(99)) < acc_pct);
      #1;
      if (bus.resultValid && bus.out_accepting_values) begin
        got_val.push_back($signed(bus.result));
        got_pos.push_back(idx - 1);
      end
      if (idx == total && bus.idle_out && !bus.resultValid) fin = 1'b1;
      else if (bus.new_data_valid && bus.idle_out) idx++;
      budget--;
      if (budget == 0) begin
        timeout = 1'b1;
        fin = 1'b1;
      end
    end
    bus.new_data_valid       = 1'b0;
    bus.out_accepting_values = 1'b0;
  endtask

  task automatic feed_pixels(input int d);
    for (int i = 0; i < d * d; i++) begin
      @(negedge clock);
      bus.new_data_valid = 1'b1;
      bus.newPixelData   = img[i / d][i % d];
    end
    @(negedge clock);
    bus.new_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %0h expected 0", bus.result);
    end
    n_tests++;
    if (bus.resultValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", bus.resultValid);
    end
    n_tests++;
    if (bus.idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 1", bus.idle_out);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_constant();
    bit to;
    set_taps(1, 0);
    apply_cfg(4, 3, 1'b0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 8'd1;
    run_frame(4, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 4) begin
      n_fail++;
      $display("FAIL const_count: got %0d results (timeout %b) expected 4", got_val.size(), to);
    end
    foreach (got_val[i]) begin
      n_tests++;
      if (got_val[i] !== 9) begin
        n_fail++;
        $display("FAIL const_value[%0d]: got %0d expected 9", i, got_val[i]);
      end
    end
  endtask

  task automatic test_sign_ext();
    bit to;
    set_taps(-1, 0);
    apply_cfg(3, 3, 1'b0);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = 8'd255;
    run_frame(3, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 1) begin
      n_fail++;
      $display("FAIL signext_count: got %0d results expected 1", got_val.size());
    end else begin
      n_tests++;
      if (got_val[0] !== -2295) begin
        n_fail++;
        $display("FAIL signext_value: got %0h expected fffff709", got_val[0]);
      end
    end
  endtask

  task automatic test_bias();
    bit to;
    set_taps(0, 1);
    rand_img(3);
    apply_cfg(3, 3, 1'b0);
    run_frame(3, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 1 || got_val[0] !== 9) begin
      n_fail++;
      $display("FAIL bias_n3: got %0d results first %0d expected 1 result 9", got_val.size(),
               (got_val.size() > 0) ? got_val[0] : 0);
    end
    apply_cfg(3, 2, 1'b0);
    run_frame(3, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 4) begin
      n_fail++;
      $display("FAIL bias_n2_count: got %0d results expected 4", got_val.size());
    end
    foreach (got_val[i]) begin
      n_tests++;
      if (got_val[i] !== 4) begin
        n_fail++;
        $display("FAIL bias_n2_value[%0d]: got %0d expected 4", i, got_val[i]);
      end
    end
  endtask

  task automatic test_sobel();
    bit to;
    int sob [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    for (int i = 0; i < 9; i++) begin
      w_arr[i] = sob[i];
      b_arr[i] = 0;
    end
    apply_cfg(5, 3, 1'b0);
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 8'(r * 10);
    run_frame(5, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 9) begin
      n_fail++;
      $display("FAIL sobel_count: got %0d results expected 9", got_val.size());
    end
    foreach (got_val[i]) begin
      n_tests++;
      if (got_val[i] !== -80) begin
        n_fail++;
        $display("FAIL sobel_value[%0d]: got %0d expected -80", i, got_val[i]);
      end
    end
  endtask

  task automatic test_stride_frames();
    bit to;
    int want_pos [4] = '{12, 14, 22, 24};
    rand_taps();
    rand_img(5);
    apply_cfg(5, 3, 1'b1);
    model_frame(5, 3, 1'b1);
    for (int f = 0; f < 2; f++) begin
      run_frame(5, 100, to);
      n_tests++;
      if (to !== 1'b0 || got_val.size() != 4) begin
        n_fail++;
        $display("FAIL stride_count[f%0d]: got %0d results expected 4", f, got_val.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_tests++;
          if (got_pos[i] !== want_pos[i] || got_val[i] !== exp_val[i]) begin
            n_fail++;
            $display("FAIL stride_result[f%0d,%0d]: got pos %0d val %0d expected pos %0d val %0d",
                     f, i, got_pos[i], got_val[i], want_pos[i], exp_val[i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit seen;
    logic [31:0] hold;
    rand_taps();
    rand_img(3);
    apply_cfg(3, 3, 1'b0);
    model_frame(3, 3, 1'b0);
    bus.out_accepting_values = 1'b0;
    feed_pixels(3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      #1;
      seen = bus.resultValid;
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_wait: resultValid got 0 expected 1 within 20 cycles");
    end
    hold = bus.result;
    n_tests++;
    if ($signed(hold) !== exp_val[0]) begin
      n_fail++;
      $display("FAIL bp_value: got %0d expected %0d", $signed(hold), exp_val[0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.new_data_valid       = 1'b1;
      bus.newPixelData         = 8'($urandom);
      bus.out_accepting_values = 1'b0;
      #1;
      n_tests++;
      if (bus.resultValid !== 1'b1 || bus.result !== hold || bus.idle_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid %b result %0h idle %b expected 1 %0h 0",
                 i, bus.resultValid, bus.result, bus.idle_out, hold);
      end
    end
    @(negedge clock);
    bus.new_data_valid       = 1'b0;
    bus.out_accepting_values = 1'b1;
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.resultValid !== 1'b0 || bus.idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got valid %b idle %b expected 0 1", bus.resultValid, bus.idle_out);
    end
    bus.out_accepting_values = 1'b0;
    // Dropped pixels must not have advanced the counters: next frame yields one window at pixel 8.
    rand_img(3);
    model_frame(3, 3, 1'b0);
    run_frame(3, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 1 || got_pos[0] !== 8 || got_val[0] !== exp_val[0]) begin
      n_fail++;
      $display("FAIL bp_next_frame: got %0d results first %0d expected 1 result %0d",
               got_val.size(), (got_val.size() > 0) ? got_val[0] : 0, exp_val[0]);
    end
  endtask

  task automatic test_reset_mid_compute();
    bit to;
    rand_taps();
    rand_img(3);
    apply_cfg(3, 3, 1'b0);
    bus.out_accepting_values = 1'b1;
    feed_pixels(3);
    #1;
    n_tests++;
    if (bus.idle_out !== 1'b0 || bus.resultValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_precompute: got idle %b valid %b expected 0 0", bus.idle_out,
               bus.resultValid);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.result !== 32'd0 || bus.resultValid !== 1'b0 || bus.idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got result %0h valid %b idle %b expected 0 0 1", bus.result,
               bus.resultValid, bus.idle_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_tests++;
      if (bus.resultValid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_hold[%0d]: valid got %b expected 0", i, bus.resultValid);
      end
    end
    reset = 1'b1;
    bus.out_accepting_values = 1'b0;
    rand_img(3);
    model_frame(3, 3, 1'b0);
    run_frame(3, 100, to);
    n_tests++;
    if (to !== 1'b0 || got_val.size() != 1 || got_pos[0] !== 8 || got_val[0] !== exp_val[0]) begin
      n_fail++;
      $display("FAIL rst_restart: got %0d results first %0d expected 1 result %0d",
               got_val.size(), (got_val.size() > 0) ? got_val[0] : 0, exp_val[0]);
    end
  endtask

  task automatic test_random();
    bit to;
    int d;
    int wd;
    bit st;
    for (int f = 0; f < 8; f++) begin
      d  = int'($urandom_range(8, 3));
      wd = int'($urandom_range(3, 0));
      st = 1'($urandom_range(1, 0));
      rand_taps();
      rand_img(d);
      apply_cfg(d, wd, st);
      model_frame(d, wd, st);
      run_frame(d, 60, to);
      n_tests++;
      if (to !== 1'b0 || got_val.size() != exp_val.size()) begin
        n_fail++;
        $display("FAIL rand_count[f%0d d%0d n%0d s%0d]: got %0d results expected %0d",
                 f, d, wd, st, got_val.size(), exp_val.size());
      end else begin
        foreach (exp_val[i]) begin
          n_tests++;
          if (got_val[i] !== exp_val[i] || got_pos[i] !== exp_pos[i]) begin
            n_fail++;
            $display("FAIL rand_result[f%0d,%0d]: got pos %0d val %0d expected pos %0d val %0d",
                     f, i, got_pos[i], got_val[i], exp_pos[i], exp_val[i]);
          end
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.new_data_valid       = 1'b0;
    bus.newPixelData         = 8'h00;
    bus.out_accepting_values = 1'b0;
    set_taps(0, 0);
    apply_cfg(3, 3, 1'b0);
    test_reset();
    test_constant();
    test_sign_ext();
    test_bias();
    test_sobel();
    test_stride_frames();
    test_backpressure();
    test_reset_mid_compute();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
